// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap controller that sequences mepc/mcause/mtval/mstatus writes
// over one CSR write port, stalls the pipeline, then redirects. Optional macro: TRAP_VECTORED_EN.
`timescale 1ns/1ps
module trap_sequencer #(
    parameter int XLEN            = 32,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_x,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] Di_PC,
    input  logic [31:0]     inst,
    input  logic            ecall,
    input  logic            illegal,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_tmr,
    input  logic            irq_sw,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            wcsr_n,
    output logic [11:0]     wr1_addr,
    output logic [XLEN-1:0] data1_in,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_EPC   = 3'd1;
    localparam logic [2:0] S_W_CAUSE = 3'd2;
    localparam logic [2:0] S_W_TVAL  = 3'd3;
    localparam logic [2:0] S_W_STAT  = 3'd4;
    localparam logic [2:0] S_R_STAT  = 3'd5;
    localparam logic [2:0] S_REDIR   = 3'd6;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    // Synchroniser chain per irq line, bit order {ext, tmr, sw}.
    logic [IRQ_SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                      irq_s;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {irq_ext, irq_tmr, irq_sw};
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign irq_s = sync_q[IRQ_SYNC_STAGES-1];

    logic p_mei, p_msi, p_mti;
    assign p_mei = irq_s[2] & mie_in[11] & mstatus_in[3];
    assign p_mti = irq_s[1] & mie_in[7]  & mstatus_in[3];
    assign p_msi = irq_s[0] & mie_in[3]  & mstatus_in[3];

    logic       take_exc, take_mret, take_irq, accept;
    logic [3:0] code_sel;
    logic [2:0] state_q, state_d;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        take_exc  = 1'b0;
        take_mret = 1'b0;
        take_irq  = 1'b0;
        code_sel  = 4'd0;
        if (illegal)     begin take_exc = 1'b1; code_sel = 4'd2;  end
        else if (ecall)  begin take_exc = 1'b1; code_sel = 4'd11; end
        else if (mret)   take_mret = 1'b1;
        else if (p_mei)  begin take_irq = 1'b1; code_sel = 4'd11; end
        else if (p_msi)  begin take_irq = 1'b1; code_sel = 4'd3;  end
        else if (p_mti)  begin take_irq = 1'b1; code_sel = 4'd7;  end
    end

    assign accept = (state_q == S_IDLE) && inst_valid && (take_exc || take_mret || take_irq);

    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    logic [3:0]      code_q, code_d;
    logic            is_irq_q, is_irq_d;
    logic [XLEN-1:0] tval_q, tval_d, mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic            wcsr_n_q, wcsr_n_d, redirect_q, redirect_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d, rpc_q, rpc_d;
    logic [XLEN-1:0] cause_word, trap_base, trap_target;

    always_comb begin
        cause_word          = '0;
        cause_word[XLEN-1]  = is_irq_q;
        cause_word[3:0]     = code_q;
    end

    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_target = (is_irq_q && mtvec_q[1:0] == 2'b01)
                       ? trap_base + XLEN'({code_q, 2'b00}) : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        is_irq_d   = is_irq_q;
        tval_d     = tval_q;
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        wcsr_n_d   = 1'b1;
        addr_d     = '0;
        data_d     = '0;
        redirect_d = 1'b0;
        rpc_d      = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    code_d    = code_sel;
                    is_irq_d  = take_irq;
                    tval_d    = '0;
                    if (illegal) tval_d[31:0] = inst;
                    mstatus_d = mstatus_in;
                    mtvec_d   = mtvec_in;
                    mepc_d    = mepc_in;
                    wcsr_n_d  = 1'b0;
                    if (take_mret) begin
                        state_d = S_R_STAT;
                        addr_d  = A_MSTATUS;
                        data_d  = mret_status(mstatus_in);
                    end else begin
                        state_d = S_W_EPC;
                        addr_d  = A_MEPC;
                        data_d  = Di_PC;
                    end
                end
            end
            S_W_EPC:   begin state_d = S_W_CAUSE; wcsr_n_d = 1'b0; addr_d = A_MCAUSE; data_d = cause_word; end
            S_W_CAUSE: begin state_d = S_W_TVAL;  wcsr_n_d = 1'b0; addr_d = A_MTVAL;  data_d = tval_q; end
            S_W_TVAL:  begin
                state_d  = S_W_STAT;
                wcsr_n_d = 1'b0;
                addr_d   = A_MSTATUS;
                data_d   = trap_status(mstatus_q);
            end
            S_W_STAT:  begin state_d = S_REDIR; redirect_d = 1'b1; rpc_d = trap_target; end
            S_R_STAT:  begin state_d = S_REDIR; redirect_d = 1'b1; rpc_d = mepc_q; end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_x) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            is_irq_q   <= 1'b0;
            tval_q     <= '0;
            mstatus_q  <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            wcsr_n_q   <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            redirect_q <= 1'b0;
            rpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            is_irq_q   <= is_irq_d;
            tval_q     <= tval_d;
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            wcsr_n_q   <= wcsr_n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            redirect_q <= redirect_d;
            rpc_q      <= rpc_d;
        end
    end

    assign wcsr_n      = wcsr_n_q;
    assign wr1_addr    = addr_q;
    assign data1_in    = data_q;
    assign redirect    = redirect_q;
    assign redirect_pc = rpc_q;
    assign trap_busy   = (state_q != S_IDLE);
    assign stall       = trap_busy | accept;

    // Enable bits for non-machine interrupt sources are not used here.
    logic unused_bits;
`ifdef TRAP_VECTORED_EN
    assign unused_bits = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};
`else
    assign unused_bits = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0], mtvec_q[1:0]};
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: randomized scoreboard bench for trap_sequencer; a reference model predicts
// CSR writes and redirects with their cycle stamps, a monitor compares them as they appear.
`timescale 1ns/1ps
module tb_trap_sequencer;
    localparam int XLEN = 32;
    localparam int SYNC = 2;

    logic            clk = 1'b0;
    logic            reset_x;
    logic            inst_valid, ecall, illegal, mret, irq_ext, irq_tmr, irq_sw;
    logic [XLEN-1:0] Di_PC, mstatus_in, mie_in, mtvec_in, mepc_in;
    logic [31:0]     inst;
    logic            wcsr_n, stall, redirect, trap_busy;
    logic [11:0]     wr1_addr;
    logic [XLEN-1:0] data1_in, redirect_pc;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(XLEN), .IRQ_SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_x(reset_x), .inst_valid(inst_valid), .Di_PC(Di_PC), .inst(inst),
        .ecall(ecall), .illegal(illegal), .mret(mret), .irq_ext(irq_ext), .irq_tmr(irq_tmr),
        .irq_sw(irq_sw), .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in),
        .mepc_in(mepc_in), .wcsr_n(wcsr_n), .wr1_addr(wr1_addr), .data1_in(data1_in),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .trap_busy(trap_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    // Bench-side view of the CSR file that drives the *_in ports.
    logic [31:0] mstatus_m, mie_m, mtvec_m, mepc_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit r, input logic [11:0] a, input logic [31:0] d, input int at);
        exp_t e;
        e.is_redir = r;
        e.addr     = a;
        e.data     = d;
        e.at       = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_x === 1'b1 && wcsr_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: actual addr=%h data=%h required=no write", wr1_addr, data1_in);
            end else begin
                e = exp_q.pop_front();
                check("write_kind", 32'(0), 32'(e.is_redir));
                check("write_cycle", 32'(cyc), 32'(e.at));
                check("write_addr", 32'(wr1_addr), 32'(e.addr));
                check("write_data", data1_in, e.data);
            end
        end
        if (reset_x === 1'b1 && redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_redirect: actual pc=%h required=no redirect", redirect_pc);
            end else begin
                e = exp_q.pop_front();
                check("redir_kind", 32'(1), 32'(e.is_redir));
                check("redir_cycle", 32'(cyc), 32'(e.at));
                check("redir_pc", redirect_pc, e.data);
                check("redir_no_write", 32'(wcsr_n), 32'(1));
            end
        end
    end

    // One request: settle the irq lines through the synchroniser, present the
    // instruction for a single cycle, predict the outcome, then follow the stall window.
    task automatic do_txn(input logic v, input logic f_ill, input logic f_ecall, input logic f_mret,
                          input logic [31:0] pc, input logic [31:0] iw, input logic [2:0] irqs);
        int          kind;   // 0 none, 1 exception, 2 mret, 3 interrupt
        int          len;
        int          n;
        logic [31:0] code, target, new_stat;
        {irq_ext, irq_tmr, irq_sw} = irqs;
        mstatus_in = mstatus_m;
        mie_in     = mie_m;
        mtvec_in   = mtvec_m;
        mepc_in    = mepc_m;
        inst_valid = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        inst_valid = v; illegal = f_ill; ecall = f_ecall; mret = f_mret; Di_PC = pc; inst = iw;
        n    = cyc;
        kind = 0;
        code = 0;
        len  = 0;
        if (v) begin
            if (f_ill)        begin kind = 1; code = 2;  end
            else if (f_ecall) begin kind = 1; code = 11; end
            else if (f_mret)  kind = 2;
            else if (mstatus_m[3]) begin
                if (irqs[2] && mie_m[11])     begin kind = 3; code = 11; end
                else if (irqs[0] && mie_m[3]) begin kind = 3; code = 3;  end
                else if (irqs[1] && mie_m[7]) begin kind = 3; code = 7;  end
            end
        end
        if (kind == 1 || kind == 3) begin
            target = mtvec_m & ~32'h3;
`ifdef TRAP_VECTORED_EN
            if (kind == 3 && mtvec_m[1:0] == 2'b01) target = target + 4 * code;
`endif
            new_stat = (mstatus_m & ~32'h88) | 32'h1800 | (mstatus_m[3] ? 32'h80 : 32'h0);
            push(0, 12'h341, pc, n + 1);
            push(0, 12'h342, (kind == 3 ? 32'h8000_0000 : 32'h0) | code, n + 2);
            push(0, 12'h343, (kind == 1 && f_ill) ? iw : 32'h0, n + 3);
            push(0, 12'h300, new_stat, n + 4);
            push(1, 12'h000, target, n + 5);
            len       = 5;
            mepc_m    = pc;
            mstatus_m = new_stat;
        end else if (kind == 2) begin
            new_stat = (mstatus_m & ~32'h88) | 32'h1880 | (mstatus_m[7] ? 32'h8 : 32'h0);
            push(0, 12'h300, new_stat, n + 1);
            push(1, 12'h000, mepc_m, n + 2);
            len       = 2;
            mstatus_m = new_stat;
        end
        @(negedge clk);
        check("accept_stall", 32'(stall), 32'(kind != 0));
        check("accept_busy", 32'(trap_busy), 32'(0));
        @(posedge clk);
        #1;
        inst_valid = 1'b0; illegal = 1'b0; ecall = 1'b0; mret = 1'b0;
        if ($urandom_range(0, 1) == 1) {irq_ext, irq_tmr, irq_sw} = 3'b000;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check("seq_stall", 32'(stall), 32'(1));
            check("seq_busy", 32'(trap_busy), 32'(1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'(0));
        check("idle_busy", 32'(trap_busy), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wcsr_n"}, 32'(wcsr_n), 32'(1));
        check({tag, "_wr1_addr"}, 32'(wr1_addr), 32'(0));
        check({tag, "_data1_in"}, data1_in, 32'h0);
        check({tag, "_stall"}, 32'(stall), 32'(0));
        check({tag, "_redirect"}, 32'(redirect), 32'(0));
        check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        check({tag, "_trap_busy"}, 32'(trap_busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_x = 1'b0;
        inst_valid = 1'b0; ecall = 1'b0; illegal = 1'b0; mret = 1'b0;
        irq_ext = 1'b0; irq_tmr = 1'b0; irq_sw = 1'b0;
        Di_PC = '0; inst = '0; mstatus_in = '0; mie_in = '0; mtvec_in = '0; mepc_in = '0;
        mstatus_m = 32'h0; mie_m = 32'h0; mtvec_m = 32'h0; mepc_m = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset_x = 1'b1;

        // ecall, illegal and mret examples.
        mtvec_m = 32'h200; mstatus_m = 32'h1888; mie_m = 32'h0; mepc_m = 32'h0;
        do_txn(1, 0, 1, 0, 32'h100, 32'h0000_0073, 3'b000);
        do_txn(1, 1, 0, 0, 32'h44, 32'hFFFF_FFFF, 3'b000);
        mstatus_m = 32'h1880; mepc_m = 32'h104;
        do_txn(1, 0, 0, 1, 32'h108, 32'h3020_0073, 3'b000);

        // Timer irq, vectored base 0x201.
        mie_m = 32'h80; mstatus_m = 32'h1888; mtvec_m = 32'h201;
        do_txn(1, 0, 0, 0, 32'h300, 32'h0000_0013, 3'b010);

        // ecall beats simultaneous irqs; MIE is then 0 until mret restores it.
        mie_m = 32'h888; mstatus_m = 32'h1888; mtvec_m = 32'h200;
        do_txn(1, 0, 1, 0, 32'h400, 32'h0000_0073, 3'b110);
        do_txn(1, 0, 0, 0, 32'h200, 32'h0000_0013, 3'b110);
        do_txn(1, 0, 0, 1, 32'h208, 32'h3020_0073, 3'b110);
        do_txn(1, 0, 0, 0, 32'h404, 32'h0000_0013, 3'b110);
        do_txn(0, 1, 1, 1, 32'h500, 32'h0000_0073, 3'b111);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) mstatus_m = $urandom;
            if ($urandom_range(0, 3) == 0) mstatus_m[3] = 1'b1;
            if ($urandom_range(0, 5) == 0) mie_m = $urandom;
            if ($urandom_range(0, 7) == 0) mtvec_m = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) mepc_m = $urandom & ~32'h3;
            do_txn($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 4) == 0, $urandom & ~32'h3, $urandom, 3'($urandom));
        end

        // Reset while in W_CAUSE: only the mepc write may be seen, no redirect afterwards.
        mstatus_m = 32'h1888; mtvec_m = 32'h200;
        {irq_ext, irq_tmr, irq_sw} = 3'b000;
        mstatus_in = mstatus_m; mtvec_in = mtvec_m;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        inst_valid = 1'b1; ecall = 1'b1; Di_PC = 32'h500;
        n = cyc;
        push(0, 12'h341, 32'h500, n + 1);
        @(posedge clk);
        #1;
        inst_valid = 1'b0; ecall = 1'b0;
        @(posedge clk);
        #2 reset_x = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 reset_x = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("post_reset_busy", 32'(trap_busy), 32'(0));
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
